// File: rtl/conv1d_pkg.sv
// Shared conv1d definitions: sizes, ring geometry and the loader FSM states.
// Imported by the window loader and the conv1d compute stage.
package conv1d_pkg;

    localparam int BYTE_SIZE          = 8;
    localparam int KERNEL_LENGTH      = 8;
    localparam int PADDING            = 4;
    localparam int MAX_INPUT_CHANNELS = 128;
    localparam int BUFFERS_SIZE       = KERNEL_LENGTH * MAX_INPUT_CHANNELS;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_WIN,
        DONE
    } conv_state_e;

endpackage

// File: rtl/conv_window_loader_if.sv
// Loader bus: input byte stream, ring-buffer write port and window handshake.
// master = loader side, slave = producer/buffer/consumer side.
interface conv_window_loader_if
    import conv1d_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_W     = BYTE_SIZE,
    parameter int SLOT_W     = $clog2(KERNEL_LENGTH)
);

    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_W-1:0]     buf_data;
    logic                  win_valid;
    logic [SLOT_W-1:0]     win_start_x;
    logic                  win_ready;

    modport master (
        input  in_valid,
        input  in_data,
        input  win_ready,
        output in_ready,
        output buf_we,
        output buf_addr,
        output buf_data,
        output win_valid,
        output win_start_x
    );

    modport slave (
        output in_valid,
        output in_data,
        output win_ready,
        input  in_ready,
        input  buf_we,
        input  buf_addr,
        input  buf_data,
        input  win_valid,
        input  win_start_x
    );

endinterface

// File: rtl/conv_window_loader.sv
// Fills an 8-slot column ring buffer with padded input columns and hands
// each complete kernel-wide window to the conv1d stage.
module conv_window_loader #(
    parameter int BYTE_SIZE          = 8,
    parameter int KERNEL_LENGTH      = 8,
    parameter int PADDING            = 4,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int ADDR_WIDTH         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           cfg_depth,
    input  logic [15:0]          cfg_width,
    input  logic [BYTE_SIZE-1:0] cfg_pad_value,
    conv_window_loader_if.master bus,
    output logic                 busy,
    output logic                 done
);

    typedef conv1d_pkg::conv_state_e state_e;

    localparam int SLOT_W  = $clog2(KERNEL_LENGTH);
    localparam int DEPTH_W = $clog2(MAX_INPUT_CHANNELS) + 1;
    localparam int COL_W   = 17;

    localparam logic [COL_W-1:0]  PAD_C     = COL_W'(PADDING);
    localparam logic [COL_W-1:0]  KL_C      = COL_W'(KERNEL_LENGTH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(KERNEL_LENGTH - 1);

    state_e                state_q, state_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [15:0]           width_q, width_d;
    logic [BYTE_SIZE-1:0]  pad_q, pad_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [DEPTH_W-1:0]    ch_q, ch_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [15:0]           consumed_q, consumed_d;
    logic [SLOT_W-1:0]     win_start_x_q, win_start_x_d;
    logic                  buf_we_q, buf_we_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [BYTE_SIZE-1:0]  buf_data_q, buf_data_d;
    logic                  win_valid_q, win_valid_d;
    logic                  done_q, done_d;

    logic                  pad_col;
    logic                  last_ch;
    logic                  col_fills_win;
    logic                  last_win;
    logic                  hs;
    logic                  in_ready_c;
    logic [SLOT_W-1:0]     slot_nxt;
    logic [SLOT_W-1:0]     wsx_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // Columns outside [PADDING, width+PADDING) carry the pad byte.
    assign pad_col  = (col_q < PAD_C)
                   || (col_q >= ({1'b0, width_q} + PAD_C));
    assign last_ch  = (ch_q == (depth_q - DEPTH_W'(1)));
    assign col_fills_win = ((col_q + COL_W'(1))
                         == ({1'b0, consumed_q} + KL_C));
    assign last_win = ((consumed_q + 16'd1) == width_q);
    assign hs       = win_valid_q && bus.win_ready;
    assign slot_nxt = (slot_q == LAST_SLOT) ? '0
                    : slot_q + SLOT_W'(1);
    assign wsx_nxt  = (win_start_x_q == LAST_SLOT) ? '0
                    : win_start_x_q + SLOT_W'(1);
    assign wr_addr  = ADDR_WIDTH'(slot_q) * ADDR_WIDTH'(depth_q)
                    + ADDR_WIDTH'(ch_q);

    always_comb begin
        state_d       = state_q;
        depth_d       = depth_q;
        width_d       = width_q;
        pad_d         = pad_q;
        col_d         = col_q;
        ch_d          = ch_q;
        slot_d        = slot_q;
        consumed_d    = consumed_q;
        win_start_x_d = win_start_x_q;
        buf_we_d      = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        win_valid_d   = 1'b0;
        in_ready_c    = 1'b0;
        done_d        = (state_q == conv1d_pkg::DONE) && !start;
        unique case (state_q)
            conv1d_pkg::IDLE,
            conv1d_pkg::DONE: begin
                if (start) begin
                    depth_d       = DEPTH_W'(cfg_depth);
                    width_d       = cfg_width;
                    pad_d         = cfg_pad_value;
                    col_d         = '0;
                    ch_d          = '0;
                    slot_d        = '0;
                    consumed_d    = '0;
                    win_start_x_d = '0;
                    if (cfg_depth == 8'd0 || cfg_width == 16'd0)
                        state_d = conv1d_pkg::DONE;
                    else
                        state_d = conv1d_pkg::WRITE;
                end
            end
            conv1d_pkg::WRITE: begin
                in_ready_c = !pad_col;
                if (pad_col || bus.in_valid) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = wr_addr;
                    buf_data_d = pad_col ? pad_q : bus.in_data;
                    if (last_ch) begin
                        ch_d   = '0;
                        slot_d = slot_nxt;
                        col_d  = col_q + COL_W'(1);
                        if (col_fills_win)
                            state_d = conv1d_pkg::WAIT_WIN;
                    end else begin
                        ch_d = ch_q + DEPTH_W'(1);
                    end
                end
            end
            conv1d_pkg::WAIT_WIN: begin
                // Delayed one cycle so the last column write lands first.
                win_valid_d = !hs;
                if (hs) begin
                    consumed_d    = consumed_q + 16'd1;
                    win_start_x_d = wsx_nxt;
                    state_d       = last_win ? conv1d_pkg::DONE
                                             : conv1d_pkg::WRITE;
                end
            end
            default: state_d = conv1d_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= conv1d_pkg::IDLE;
            depth_q       <= '0;
            width_q       <= '0;
            pad_q         <= '0;
            col_q         <= '0;
            ch_q          <= '0;
            slot_q        <= '0;
            consumed_q    <= '0;
            win_start_x_q <= '0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            win_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            width_q       <= width_d;
            pad_q         <= pad_d;
            col_q         <= col_d;
            ch_q          <= ch_d;
            slot_q        <= slot_d;
            consumed_q    <= consumed_d;
            win_start_x_q <= win_start_x_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            win_valid_q   <= win_valid_d;
            done_q        <= done_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.buf_we      = buf_we_q;
    assign bus.buf_addr    = buf_addr_q;
    assign bus.buf_data    = buf_data_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_start_x = win_start_x_q;
    assign busy = (state_q == conv1d_pkg::WRITE)
               || (state_q == conv1d_pkg::WAIT_WIN);
    assign done = done_q;

endmodule

// File: tb/tb_conv_window_loader.sv
// Scoreboard bench for conv_window_loader: expected ring writes are queued
// from a column model and popped as buf_we beats appear.
module tb_conv_window_loader;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_depth = '0;
    logic [15:0] cfg_width = '0;
    logic [7:0]  cfg_pad_value = '0;
    logic        busy;
    logic        done;

    conv_window_loader_if bus ();

    conv_window_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_depth     (cfg_depth),
        .cfg_width     (cfg_width),
        .cfg_pad_value (cfg_pad_value),
        .bus           (bus),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  wr_cnt = 0;
    bit  abort = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        wr_t  e;
        bit   prev_wv = 1'b0;
        logic [2:0] prev_x = '0;
        forever begin
            @(negedge clk);
            if (bus.buf_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_we", 32'(bus.buf_addr), 32'hffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.buf_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.buf_data), 32'(e.data));
                end
            end
            if (bus.win_valid && prev_wv)
                chk("wsx_stable", 32'(bus.win_start_x), 32'(prev_x));
            prev_wv = bus.win_valid;
            prev_x  = bus.win_start_x;
        end
    endtask

    task automatic expect_pass(input int depth, input int width,
                               input logic [7:0] pad);
        wr_t e;
        for (int c = 0; c < width + 7; c++) begin
            for (int ch = 0; ch < depth; ch++) begin
                e.addr = 10'(((c % 8) * depth) + ch);
                if (c < 4 || c >= width + 4)
                    e.data = pad;
                else
                    e.data = 8'(((c - 4) * depth) + ch + 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic feed(input int n, input bit gappy);
        int i = 0;
        int cyc = 0;
        bit tog = 1'b0;
        while (i < n && !abort && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            tog = ~tog;
            bus.in_valid = gappy ? tog : 1'b1;
            bus.in_data  = 8'(i + 1);
            if (bus.in_valid && bus.in_ready)
                i++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!abort)
            chk("feed_count", 32'(i), 32'(n));
    endtask

    task automatic take_window(input logic [2:0] exp_x, input int exp_wr,
                               input int hold);
        int cyc = 0;
        int n0;
        while (!bus.win_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("win_seen", 32'(bus.win_valid), 32'd1);
        chk("win_x", 32'(bus.win_start_x), 32'(exp_x));
        chk("wr_before_win", 32'(wr_cnt), 32'(exp_wr));
        if (hold > 0) begin
            n0 = wr_cnt;
            repeat (hold) @(negedge clk);
            chk("hold_no_we", 32'(wr_cnt), 32'(n0));
            chk("hold_wv", 32'(bus.win_valid), 32'd1);
            chk("hold_x", 32'(bus.win_start_x), 32'(exp_x));
        end
        bus.win_ready = 1'b1;
        @(negedge clk);
        bus.win_ready = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic run_pass(input int depth, input int width,
                            input logic [7:0] pad, input bit gappy,
                            input bit poke);
        int base = wr_cnt;
        expect_pass(depth, width, pad);
        @(negedge clk);
        cfg_depth     = 8'(depth);
        cfg_width     = 16'(width);
        cfg_pad_value = pad;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        chk("done_clr", 32'(done), 32'd0);
        fork
            feed(depth * width, gappy);
        join_none
        // stray win_ready before any window exists
        bus.win_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.win_ready = 1'b0;
        for (int k = 0; k < width; k++) begin
            take_window(3'(k % 8), base + depth * (8 + k),
                        (k == 1) ? 20 : 0);
            if (poke && k == 0) begin
                start     = 1'b1;
                cfg_depth = 8'd9;
                cfg_width = 16'd1;
                @(negedge clk);
                start     = 1'b0;
                cfg_depth = 8'(depth);
                cfg_width = 16'(width);
            end
        end
        wait_done();
        chk("wr_total", 32'(wr_cnt - base), 32'(depth * (width + 7)));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int cyc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
        chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        chk("rst_buf_data", 32'(bus.buf_data), 32'd0);
        chk("rst_win_valid", 32'(bus.win_valid), 32'd0);
        chk("rst_wsx", 32'(bus.win_start_x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_pass(2, 3, 8'h80, 1'b0, 1'b0);
        run_pass(2, 3, 8'h80, 1'b1, 1'b1);
        run_pass(3, 10, 8'hc3, 1'b1, 1'b0);

        // reset in the middle of a data column
        base = wr_cnt;
        expect_pass(2, 3, 8'h80);
        cfg_depth = 8'd2;
        cfg_width = 16'd3;
        cfg_pad_value = 8'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            feed(6, 1'b0);
        join_none
        cyc = 0;
        while (wr_cnt - base < 11 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_wr_reached", 32'(wr_cnt - base >= 11), 32'd1);
        rst_n = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("mrst_buf_we", 32'(bus.buf_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_win_valid", 32'(bus.win_valid), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_we", 32'(bus.buf_we), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        chk("post_rst_we2", 32'(bus.buf_we), 32'd0);
        run_pass(1, 1, 8'h5a, 1'b0, 1'b0);

        // zero width and zero depth finish without writes
        for (int z = 0; z < 2; z++) begin
            base = wr_cnt;
            cfg_depth = (z == 0) ? 8'd2 : 8'd0;
            cfg_width = (z == 0) ? 16'd0 : 16'd4;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_done_early", 32'(done), 32'd0);
            @(negedge clk);
            chk("zero_done", 32'(done), 32'd1);
            repeat (3) @(negedge clk);
            chk("zero_writes", 32'(wr_cnt - base), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
